// File: rtl/daq_buffer_reader.sv
// Read-side engine for the DAQ event buffer: walks the 64-bit read port, absorbs the fixed
// read latency and re-streams the words as a valid/ready stream with full backpressure.
module daq_buffer_reader #(
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [14:0] start_addr,
   input  logic [14:0] nwords,
   input  logic        abort,
   output logic [14:0] rd_addr,
   input  logic [63:0] rd_data64,
   output logic [63:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e             state_q, state_d;
   logic [14:0]        addr_q, addr_d;
   logic [14:0]        remaining_q, remaining_d;
   logic [14:0]        rd_addr_q, rd_addr_d;
   logic               done_q, done_d;
   logic [RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]  pipe_last_q, pipe_last_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]        count_q, count_d;
   logic [63:0]        fifo_data [FIFO_DEPTH];
   logic               fifo_last [FIFO_DEPTH];

   logic               push, pop, issue;
   logic [7:0]         inflight;

   assign push = pipe_vld_q[RD_LAT-1];
   assign pop  = (count_q != '0) && m_ready;

   // Credit: reads in flight plus stored words never exceed the FIFO size.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + 8'(pipe_vld_q[i]);
      end
   end

   assign issue = (state_q == StIssue) && !abort &&
                  ((inflight + 8'(count_q)) < 8'(FIFO_DEPTH));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      rd_addr_d   = rd_addr_q;
      done_d      = 1'b0;
      pipe_vld_d  = pipe_vld_q << 1;
      pipe_vld_d[0]  = issue;
      pipe_last_d = pipe_last_q << 1;
      pipe_last_d[0] = issue && (remaining_q == 15'd1);
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               if (nwords != '0) begin
                  addr_d      = {start_addr[14:1], 1'b0};
                  remaining_d = nwords;
                  state_d     = StIssue;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StIssue: begin
            if (issue) begin
               rd_addr_d   = addr_q;
               addr_d      = addr_q + 15'd2;
               remaining_d = remaining_q - 15'd1;
               if (remaining_q == 15'd1) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && fifo_last[rd_ptr_q]) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A transfer in the abort cycle still happens; everything else is dropped.
      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         done_d      = 1'b0;
         pipe_vld_d  = '0;
         pipe_last_d = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         remaining_q <= '0;
         rd_addr_q   <= '0;
         done_q      <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         rd_addr_q   <= rd_addr_d;
         done_q      <= done_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_q] <= rd_data64;
         fifo_last[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
      end
   end

   assign rd_addr = rd_addr_q;
   assign m_valid = (count_q != '0);
   assign m_data  = m_valid ? fifo_data[rd_ptr_q] : '0;
   assign m_last  = m_valid && fifo_last[rd_ptr_q];
   assign busy    = (state_q != StIdle);
   assign done    = done_q;

endmodule
